cdb_arbiter: RTL

//   Schedules the common data bus that feeds the ROB completion ports (cdb_pr_ready/cdb_pr_tag_*).
//   Up to NUM_FU functional units request broadcast of a completed 7-bit physical-register tag;
//   the arbiter grants up to CDB_WIDTH per cycle by rotating priority and registers the winners

---
 rtl/cdb_arbiter_if.sv | 24 ++
 rtl/cdb_arbiter.sv | 122 ++++++++++++
 2 files changed

// File: rtl/cdb_arbiter_if.sv
// CDB arbiter bus: FU request/grant handshake plus the registered CDB slots.
// master = FU/ROB side, slave = arbiter.
interface cdb_arbiter_if #(
  parameter int NUM_FU    = 8,
  parameter int CDB_WIDTH = 2
);
  logic [NUM_FU-1:0]      fu_req;
  logic [7*NUM_FU-1:0]    fu_tag;
  logic                   rob_flush;
  logic [NUM_FU-1:0]      fu_grant;
  logic [CDB_WIDTH-1:0]   cdb_pr_ready;
  logic [7*CDB_WIDTH-1:0] cdb_pr_tag;
  logic                   cdb_busy;

  modport master (
    output fu_req, fu_tag, rob_flush,
    input  fu_grant, cdb_pr_ready, cdb_pr_tag, cdb_busy
  );

  modport slave (
    input  fu_req, fu_tag, rob_flush,
    output fu_grant, cdb_pr_ready, cdb_pr_tag, cdb_busy
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Rotating-priority CDB arbiter: up to CDB_WIDTH FU tags per cycle onto the CDB.
// Define CDB_FU0_PRIORITY_EN to give FU 0 a fixed slot 0 outside the rotation.
module cdb_arbiter #(
  parameter int NUM_FU    = 8,
  parameter int CDB_WIDTH = 2,
  parameter int PTR_W     = 3
) (
  input logic          clock,
  input logic          reset,
  cdb_arbiter_if.slave bus
);

  localparam logic [PTR_W-1:0] ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_FU - 1);
  localparam logic [7*CDB_WIDTH-1:0] NO_TAG = {CDB_WIDTH{7'h7f}};
`ifdef CDB_FU0_PRIORITY_EN
  localparam logic [PTR_W-1:0] PTR_RST = ONE;
`else
  localparam logic [PTR_W-1:0] PTR_RST = '0;
`endif

  logic [6:0]             tag_a [NUM_FU];
  logic [PTR_W-1:0]       rr_ptr;
  logic [PTR_W-1:0]       rr_nxt;
  logic [PTR_W-1:0]       idx;
  logic [PTR_W-1:0]       last;
  logic                   any_rot;
  logic [NUM_FU-1:0]      grant;
  logic [CDB_WIDTH-1:0]   slot_vld;
  logic [7*CDB_WIDTH-1:0] slot_tag;
  logic [CDB_WIDTH-1:0]   ready_q;
  logic [7*CDB_WIDTH-1:0] tag_q;
  logic                   busy_q;
  logic                   busy_nxt;
  int                     cnt;
  int                     nreq;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_tag
    assign tag_a[i] = bus.fu_tag[7*i +: 7];
  end

  always_comb begin
    grant    = '0;
    slot_vld = '0;
    slot_tag = NO_TAG;
    cnt      = 0;
    nreq     = 0;
    idx      = rr_ptr;
    last     = rr_ptr;
    any_rot  = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      nreq += int'(bus.fu_req[i]);
    end
`ifdef CDB_FU0_PRIORITY_EN
    if (bus.fu_req[0]) begin
      grant[0]      = 1'b1;
      slot_vld[0]   = 1'b1;
      slot_tag[6:0] = tag_a[0];
      cnt           = 1;
    end
    for (int k = 0; k < NUM_FU - 1; k++) begin
      if (bus.fu_req[idx] && cnt < CDB_WIDTH) begin
        grant[idx] = 1'b1;
        for (int s = 0; s < CDB_WIDTH; s++) begin
          if (cnt == s) begin
            slot_vld[s]         = 1'b1;
            slot_tag[7*s +: 7]  = tag_a[idx];
          end
        end
        cnt++;
        last    = idx;
        any_rot = 1'b1;
      end
      idx = (idx == LAST) ? ONE : idx + ONE;
    end
    rr_nxt = !any_rot ? rr_ptr :
             (last == LAST) ? ONE : last + ONE;
`else
    for (int k = 0; k < NUM_FU; k++) begin
      if (bus.fu_req[idx] && cnt < CDB_WIDTH) begin
        grant[idx] = 1'b1;
        for (int s = 0; s < CDB_WIDTH; s++) begin
          if (cnt == s) begin
            slot_vld[s]         = 1'b1;
            slot_tag[7*s +: 7]  = tag_a[idx];
          end
        end
        cnt++;
        last    = idx;
        any_rot = 1'b1;
      end
      idx = idx + ONE;
    end
    rr_nxt = any_rot ? last + ONE : rr_ptr;
`endif
    busy_nxt = (nreq > CDB_WIDTH);
  end

  // Flush squashes the grant so FUs keep holding their results.
  assign bus.fu_grant     = (reset || bus.rob_flush) ? '0 : grant;
  assign bus.cdb_pr_ready = ready_q;
  assign bus.cdb_pr_tag   = tag_q;
  assign bus.cdb_busy     = busy_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr  <= PTR_RST;
      ready_q <= '0;
      tag_q   <= NO_TAG;
      busy_q  <= 1'b0;
    end else if (bus.rob_flush) begin
      ready_q <= '0;
      tag_q   <= NO_TAG;
    end else begin
      rr_ptr  <= rr_nxt;
      ready_q <= slot_vld;
      tag_q   <= slot_tag;
      busy_q  <= busy_nxt;
    end
  end

endmodule
